fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sequences the program counter and instruction-memory fetch for the single-issue ARM core. Owns the PC register and the +4 increment, and issues one fetch request at a time over a req/ready handshake. Applies branch and exception redirects with flush, and presents a single-entry instruction buffer to decode, with a stall input from the hazard unit.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
EXC_VECTOR, 32'h0000_0004, redirect target when exc_req is asserted.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  decode cannot accept; holds the instruction buffer.
branch_taken  input  1  redirect fetch to branch_target this cycle.
branch_target  input  32  branch destination; bits [1:0] ignored (forced 0).
exc_req  input  1  redirect to EXC_VECTOR; has priority over branch_taken.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address, word aligned.
imem_ready  input  1  memory accepts the request; imem_rdata valid in the same cycle.
imem_rdata  input  32  fetched instruction word.
instr_valid  output  1  instruction buffer holds a valid instruction.
instr  output  32  buffered instruction.
instr_pc  output  32  address of the buffered instruction.
instr_pc_plus8  output  32  instr_pc + 8 (ARM PC-read value), combinational from instr_pc.

Behaviour:
- Reset (async): state=BOOT, pc=RESET_VECTOR, pending=0, instr_valid=0, instr=0, instr_pc=0. Outputs imem_req=0, imem_addr=RESET_VECTOR.
- redirect = exc_req | branch_taken; target = exc_req ? EXC_VECTOR : {branch_target[31:2],2'b00}.
- Handshake rules:
  - At most one request outstanding.
  - Once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ready=1.
  - Transfer occurs when imem_req & imem_ready.
- Buffer consume: decode consumes when instr_valid & !stall.
- BOOT:
  - imem_req=0.
  - Next state RUN.
  - A redirect in BOOT loads pc<=target.
- RUN (no request outstanding):
  - imem_req = !redirect & (!instr_valid | !stall).
  - imem_addr=pc.
  - On transfer: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, stay RUN (zero-wait memory gives 1 instruction per cycle).
  - If imem_req & !imem_ready: go to BUSY.
  - If no request and buffer consumed: instr_valid<=0.
  - On redirect: pc<=target, instr_valid<=0 (flush overrides stall), no request that cycle.
- BUSY (request outstanding, buffer empty by construction):
  - imem_req=1, addr=pc.
  - Transfer without redirect: load buffer as above, pc<=pc+4, go to RUN.
  - Redirect with transfer: discard rdata, pc<=target, instr_valid stays 0, go to RUN.
  - Redirect without transfer: pending<=target, go to DRAIN.
- DRAIN (stale request outstanding):
  - imem_req=1, addr=pc (old).
  - A new redirect overwrites pending (later cycle wins; exc beats branch within a cycle).
  - On transfer: discard rdata; pc<=(redirect ? target : pending), go to RUN.
  - instr_valid=0 throughout.
- Invariants:
  - A new request is only issued when the buffer is empty or being consumed, so returning data never overwrites an unconsumed instruction.
  - pc wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0); no carry out.
  - Reset asserted mid-transaction aborts immediately; memory is required to tolerate a dropped request.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, RUN, BUSY, DRAIN} (2 bits).
  - PC_STEP=32'd4, PC_READ_OFFSET=32'd8.
  - Defaults for RESET_VECTOR and EXC_VECTOR.
- One sub-module, fetch_buffer: single-entry instr/instr_pc/instr_valid register with load, consume and flush inputs, plus the +8 adder.
- The PC register, next-PC mux and FSM stay in fetch_sequencer.

Test Plan:
- Reset release, imem_ready tied 1, stall=0 -> requests at 0x0, 0x4, 0x8 on consecutive cycles. instr_valid rises 2 cycles after reset deasserts; instr_pc=0x0 with instr_pc_plus8=0x8.
- imem_ready delayed 3 cycles on addr 0x4 -> imem_req and imem_addr=0x4 held stable 3 cycles; the instruction appears the cycle after ready, then the next request is to 0x8.
- stall=1 for 4 cycles with buffer holding pc 0x8 -> no new imem_req, instr/instr_pc unchanged. After stall drops, the next request is to 0xC in the same cycle.
- branch_taken, branch_target=0x103, in BUSY at addr 0x10 with ready late by 2 cycles -> DRAIN, addr 0x10 held until ready, its data discarded (instr_valid=0). The next request is to 0x100.
- exc_req and branch_taken (target 0x200) in the same RUN cycle with a valid buffer and stall=1 -> instr_valid=0 next cycle, the next request is to 0x4.
- pc=0xFFFF_FFFC, ready=1 -> fetch at 0xFFFF_FFFC, then at 0x0. Async reset asserted mid-BUSY -> imem_req=0 immediately, pc=RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      BUSY  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] PC_READ_OFFSET   = 32'd8;
   localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0004;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready bus between the fetch sequencer and imem.
interface fetch_sequencer_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_buffer.sv
// Single-entry instruction buffer presented to decode, with the ARM PC-read (+8) value.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        consume,
   input  logic        flush,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus8
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;

   // flush beats load beats consume; a load in the consume cycle refills the slot
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = load_instr;
         pc_d    = load_pc;
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= 32'd0;
         pc_q    <= 32'd0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign instr_valid    = valid_q;
   assign instr          = instr_q;
   assign instr_pc       = pc_q;
   assign instr_pc_plus8 = pc_q + PC_READ_OFFSET;

endmodule

// File: rtl/fetch_sequencer.sv
// PC register, next-PC selection and fetch FSM issuing one imem request at a time.
//
// state | meaning
// BOOT  | first cycle after reset, no request; a redirect here retargets pc
// RUN   | no request outstanding; issue at pc when buffer can take the result
// BUSY  | request at pc outstanding, buffer empty, waiting for imem_ready
// DRAIN | stale request outstanding after a redirect; result is discarded
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     branch_taken,
   input  logic [31:0]              branch_target,
   input  logic                     exc_req,
   fetch_sequencer_if.master        imem,
   output logic                     instr_valid,
   output logic [31:0]              instr,
   output logic [31:0]              instr_pc,
   output logic [31:0]              instr_pc_plus8
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pending_q, pending_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_inc;
   logic        req;
   logic        buf_load;
   logic        buf_flush;
   logic        buf_consume;

   assign redirect    = exc_req | branch_taken;
   assign target      = exc_req ? EXC_VECTOR : (branch_target & WORD_MASK);
   assign pc_inc      = pc_q + PC_STEP;
   assign buf_consume = instr_valid & ~stall;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pending_d = pending_q;
      req       = 1'b0;
      buf_load  = 1'b0;
      buf_flush = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
            if (redirect) pc_d = target;
         end
         RUN: begin
            req = ~redirect & (~instr_valid | ~stall);
            if (redirect) begin
               pc_d      = target;
               buf_flush = 1'b1;
            end else if (req && imem.imem_ready) begin
               buf_load = 1'b1;
               pc_d     = pc_inc;
            end else if (req) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            req = 1'b1;
            if (redirect) begin
               buf_flush = 1'b1;
               if (imem.imem_ready) begin
                  pc_d    = target;
                  state_d = RUN;
               end else begin
                  pending_d = target;
                  state_d   = DRAIN;
               end
            end else if (imem.imem_ready) begin
               buf_load = 1'b1;
               pc_d     = pc_inc;
               state_d  = RUN;
            end
         end
         DRAIN: begin
            req = 1'b1;
            // the newest redirect wins over the one captured earlier
            if (redirect) pending_d = target;
            if (imem.imem_ready) begin
               pc_d    = redirect ? target : pending_q;
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= BOOT;
         pc_q      <= RESET_VECTOR;
         pending_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
      end
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_q;

   fetch_buffer u_buffer (
      .clk            (clk),
      .reset          (reset),
      .load           (buf_load),
      .consume        (buf_consume),
      .flush          (buf_flush),
      .load_instr     (imem.imem_rdata),
      .load_pc        (pc_q),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc_plus8 (instr_pc_plus8)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses and decoded
// instructions are queued by the stimulus and popped by a negedge monitor.
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        exc_req;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus8;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .exc_req        (exc_req),
      .imem           (bus),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc_plus8 (instr_pc_plus8)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_dec_q[$];
   logic [31:0] mon_e;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hE3A0_5A00;
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: every transfer and every decode consume pops one entry
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.imem_req && bus.imem_ready) begin
            if (exp_addr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL fetch_unexpected: got addr %h expected no transfer", bus.imem_addr);
            end else begin
               mon_e = exp_addr_q.pop_front();
               check32("fetch_addr", bus.imem_addr, mon_e);
            end
         end
         if (instr_valid && !stall) begin
            if (exp_dec_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL decode_unexpected: got pc %h expected no instruction", instr_pc);
            end else begin
               mon_e = exp_dec_q.pop_front();
               check32("dec_pc", instr_pc, mon_e);
               check32("dec_instr", instr, mem_word(mon_e));
               check32("dec_pc_plus8", instr_pc_plus8, mon_e + 32'd8);
            end
         end
      end
   end

   task automatic start_phase();
      reset         = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      exc_req       = 1'b0;
      branch_target = 32'd0;
      bus.imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic end_phase();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset          = 1'b1;
      stall          = 1'b0;
      branch_taken   = 1'b0;
      exc_req        = 1'b0;
      branch_target  = 32'd0;
      bus.imem_ready = 1'b1;

      @(negedge clk);
      check1("rst_req", bus.imem_req, 1'b0);
      check32("rst_addr", bus.imem_addr, 32'h0);
      check1("rst_valid", instr_valid, 1'b0);
      check32("rst_instr", instr, 32'h0);
      check32("rst_instr_pc", instr_pc, 32'h0);

      // streaming with zero-wait memory
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      exp_dec_q  = '{32'h0, 32'h4};
      start_phase();
      @(negedge clk);
      check1("boot_req", bus.imem_req, 1'b0);
      @(negedge clk);
      check1("stream_valid_c1", instr_valid, 1'b0);
      check32("stream_addr_c1", bus.imem_addr, 32'h0);
      @(negedge clk);
      check1("stream_valid_c2", instr_valid, 1'b1);
      check32("stream_pc_c2", instr_pc, 32'h0);
      check32("stream_plus8_c2", instr_pc_plus8, 32'h8);
      @(negedge clk);
      end_phase();

      // ready held low for three cycles on 0x4
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      exp_dec_q  = '{32'h0, 32'h4};
      start_phase();
      step();
      step();
      bus.imem_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check1("wait_req_held", bus.imem_req, 1'b1);
         check32("wait_addr_held", bus.imem_addr, 32'h4);
         step();
      end
      bus.imem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check1("wait_valid_after", instr_valid, 1'b1);
      check32("wait_pc_after", instr_pc, 32'h4);
      end_phase();

      // stall with buffer holding 0x8
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      exp_dec_q  = '{32'h0, 32'h4, 32'h8};
      start_phase();
      repeat (4) step();
      stall = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check1("stall_no_req", bus.imem_req, 1'b0);
         check1("stall_valid", instr_valid, 1'b1);
         check32("stall_pc", instr_pc, 32'h8);
         check32("stall_instr", instr, mem_word(32'h8));
      end
      step();
      stall = 1'b0;
      @(negedge clk);
      check1("unstall_req", bus.imem_req, 1'b1);
      check32("unstall_addr", bus.imem_addr, 32'hC);
      end_phase();

      // branch while BUSY at 0x10 -> DRAIN, then 0x100
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104};
      exp_dec_q  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100};
      start_phase();
      repeat (5) step();
      bus.imem_ready = 1'b0;
      step();
      branch_taken  = 1'b1;
      branch_target = 32'h103;
      @(negedge clk);
      check32("busy_addr", bus.imem_addr, 32'h10);
      step();
      branch_taken = 1'b0;
      @(negedge clk);
      check1("drain_req", bus.imem_req, 1'b1);
      check32("drain_addr", bus.imem_addr, 32'h10);
      check1("drain_valid", instr_valid, 1'b0);
      step();
      bus.imem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check1("drain_discard", instr_valid, 1'b0);
      check32("drain_next_addr", bus.imem_addr, 32'h100);
      @(negedge clk);
      check32("branch_pc", instr_pc, 32'h100);
      end_phase();

      // exc + branch together under stall: exception wins and flushes
      exp_addr_q = '{32'h0, 32'h4, 32'h4, 32'h8};
      exp_dec_q  = '{32'h0, 32'h4};
      start_phase();
      repeat (3) step();
      stall         = 1'b1;
      exc_req       = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      @(negedge clk);
      check1("exc_no_req", bus.imem_req, 1'b0);
      step();
      exc_req      = 1'b0;
      branch_taken = 1'b0;
      @(negedge clk);
      check1("exc_flushed", instr_valid, 1'b0);
      check1("exc_req_next", bus.imem_req, 1'b1);
      check32("exc_addr_next", bus.imem_addr, 32'h4);
      step();
      stall = 1'b0;
      @(negedge clk);
      end_phase();

      // pc wrap at the top of the address space, then async reset in BUSY
      exp_addr_q = '{32'hFFFF_FFFC, 32'h0};
      exp_dec_q  = '{32'hFFFF_FFFC, 32'h0};
      start_phase();
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      @(negedge clk);
      check1("wrap_boot_req", bus.imem_req, 1'b0);
      step();
      branch_taken = 1'b0;
      @(negedge clk);
      check32("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      check32("wrap_addr_zero", bus.imem_addr, 32'h0);
      check32("wrap_plus8", instr_pc_plus8, 32'h4);
      step();
      bus.imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check1("busy_req", bus.imem_req, 1'b1);
      check32("busy_addr4", bus.imem_addr, 32'h4);
      #2 reset = 1'b1;
      #1;
      check1("async_rst_req", bus.imem_req, 1'b0);
      check32("async_rst_pc", bus.imem_addr, 32'h0);
      check1("async_rst_valid", instr_valid, 1'b0);

      repeat (3) @(negedge clk);
      check32("fetch_queue_empty", 32'(exp_addr_q.size()), 32'd0);
      check32("decode_queue_empty", 32'(exp_dec_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
